// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Optional response watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            i_if_req_valid,
  output logic            o_if_req_ready,
  input  logic [XLEN-1:0] i_if_addr,
  output logic            o_if_rsp_valid,
  output logic [XLEN-1:0] o_if_rsp_data,
  input  logic            i_d_req_valid,
  output logic            o_d_req_ready,
  input  logic            i_d_we,
  input  logic [XLEN-1:0] i_d_addr,
  input  logic [XLEN-1:0] i_d_wdata,
  output logic            o_d_rsp_valid,
  output logic [XLEN-1:0] o_d_rsp_data,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_rsp_valid,
  input  logic [XLEN-1:0] i_mem_rsp_data,
  output logic            o_bus_error
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  localparam logic OwnFetch = 1'b0;
  localparam logic OwnData  = 1'b1;

  state_e          r_state;
  logic            r_owner;
  logic            r_last_grant;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;

  logic            w_grant_if;
  logic            w_grant_d;
  logic            w_accept_if;
  logic            w_accept_d;
  logic            w_rsp_normal;
  logic            w_timeout;
  logic            w_rsp_done;
  logic [XLEN-1:0] w_rsp_data;

  // On a tie the side that did not win last time gets the port.
  assign w_grant_if = i_if_req_valid && (!i_d_req_valid || (r_last_grant == OwnData));
  assign w_grant_d  = i_d_req_valid && (!i_if_req_valid || (r_last_grant == OwnFetch));

  assign o_if_req_ready = n_rst && (r_state == StIdle) && w_grant_if;
  assign o_d_req_ready  = n_rst && (r_state == StIdle) && w_grant_d;
  assign w_accept_if    = i_if_req_valid && o_if_req_ready;
  assign w_accept_d     = i_d_req_valid && o_d_req_ready;

  assign o_mem_req_valid = n_rst && (r_state == StReq);
  assign o_mem_we        = r_we;
  assign o_mem_addr      = r_addr;
  assign o_mem_wdata     = r_wdata;

  assign w_rsp_normal = n_rst && (r_state == StRsp) && i_mem_rsp_valid;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_bus_error;

  assign w_timeout = n_rst && (r_state == StRsp) && !i_mem_rsp_valid &&
                     (r_cnt == 8'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_cnt       <= '0;
      r_bus_error <= 1'b0;
    end else begin
      if (r_state != StRsp) begin
        r_cnt <= '0;
      end else if (!i_mem_rsp_valid) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_timeout) begin
        r_bus_error <= 1'b1;
      end
    end
  end

  assign o_bus_error = r_bus_error;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign o_bus_error      = 1'b0;
`endif

  assign w_rsp_done = w_rsp_normal || w_timeout;
  // Store acks and timeouts carry zero data.
  assign w_rsp_data = (w_rsp_normal && !((r_owner == OwnData) && r_we)) ? i_mem_rsp_data : '0;

  assign o_if_rsp_valid = w_rsp_done && (r_owner == OwnFetch);
  assign o_d_rsp_valid  = w_rsp_done && (r_owner == OwnData);
  assign o_if_rsp_data  = o_if_rsp_valid ? w_rsp_data : '0;
  assign o_d_rsp_data   = o_d_rsp_valid ? w_rsp_data : '0;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state      <= StIdle;
      r_owner      <= OwnFetch;
      r_last_grant <= OwnData;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept_if) begin
            r_owner      <= OwnFetch;
            r_last_grant <= OwnFetch;
            r_we         <= 1'b0;
            r_addr       <= i_if_addr;
            r_wdata      <= '0;
            r_state      <= StReq;
          end else if (w_accept_d) begin
            r_owner      <= OwnData;
            r_last_grant <= OwnData;
            r_we         <= i_d_we;
            r_addr       <= i_d_addr;
            r_wdata      <= i_d_wdata;
            r_state      <= StReq;
          end
        end
        StReq: begin
          if (i_mem_req_ready) begin
            r_state <= StRsp;
          end
        end
        StRsp: begin
          if (w_rsp_done) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic,
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TO   = 4;

  logic            clk;
  logic            n_rst;
  logic            if_req_valid, if_req_ready, if_rsp_valid;
  logic [XLEN-1:0] if_addr, if_rsp_data;
  logic            d_req_valid, d_req_ready, d_we, d_rsp_valid;
  logic [XLEN-1:0] d_addr, d_wdata, d_rsp_data;
  logic            mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid, bus_error;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rsp_data;

  mem_port_arbiter #(
    .XLEN          (XLEN),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_if_req_valid (if_req_valid),
    .o_if_req_ready (if_req_ready),
    .i_if_addr      (if_addr),
    .o_if_rsp_valid (if_rsp_valid),
    .o_if_rsp_data  (if_rsp_data),
    .i_d_req_valid  (d_req_valid),
    .o_d_req_ready  (d_req_ready),
    .i_d_we         (d_we),
    .i_d_addr       (d_addr),
    .i_d_wdata      (d_wdata),
    .o_d_rsp_valid  (d_rsp_valid),
    .o_d_rsp_data   (d_rsp_data),
    .o_mem_req_valid(mem_req_valid),
    .i_mem_req_ready(mem_req_ready),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rsp_valid(mem_rsp_valid),
    .i_mem_rsp_data (mem_rsp_data),
    .o_bus_error    (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                          input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: at most one outstanding transaction.
  typedef struct {
    bit              is_data;
    bit              we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    bit              mem_took;
    int unsigned     waited;
  } txn_t;

  txn_t cur;
  bit   pending   = 0;
  bit   last_data = 1;
  bit   err_seen  = 0;
  int   grants_if = 0;
  int   grants_d  = 0;

  task automatic step(input bit rst, input bit ifv, input logic [XLEN-1:0] ia,
                      input bit dv, input bit dwe, input logic [XLEN-1:0] da,
                      input logic [XLEN-1:0] dw, input bit mrr, input bit mrv,
                      input logic [XLEN-1:0] mrd);
    bit              e_ifr, e_dr, e_mv, e_rsp, e_to;
    logic [XLEN-1:0] e_data;
    @(negedge clk);
    n_rst = rst; if_req_valid = ifv; if_addr = ia;
    d_req_valid = dv; d_we = dwe; d_addr = da; d_wdata = dw;
    mem_req_ready = mrr; mem_rsp_valid = mrv; mem_rsp_data = mrd;
    #1;
    e_ifr = rst && !pending && ifv && (!dv || last_data);
    e_dr  = rst && !pending && dv && (!ifv || !last_data);
    e_mv  = rst && pending && !cur.mem_took;
`ifdef MEM_TIMEOUT_EN
    e_to  = rst && pending && cur.mem_took && !mrv && (cur.waited == TO);
`else
    e_to  = 1'b0;
`endif
    e_rsp  = (rst && pending && cur.mem_took && mrv) || e_to;
    e_data = (e_rsp && mrv && !(cur.is_data && cur.we)) ? mrd : '0;
    check_eq("if_req_ready", XLEN'(if_req_ready), XLEN'(e_ifr));
    check_eq("d_req_ready", XLEN'(d_req_ready), XLEN'(e_dr));
    check_eq("mem_req_valid", XLEN'(mem_req_valid), XLEN'(e_mv));
    if (e_mv) begin
      check_eq("mem_addr", mem_addr, cur.addr);
      check_eq("mem_we", XLEN'(mem_we), XLEN'(cur.we));
      if (cur.we) check_eq("mem_wdata", mem_wdata, cur.wdata);
    end
    check_eq("if_rsp_valid", XLEN'(if_rsp_valid), XLEN'(e_rsp && !cur.is_data));
    check_eq("if_rsp_data", if_rsp_data, (e_rsp && !cur.is_data) ? e_data : '0);
    check_eq("d_rsp_valid", XLEN'(d_rsp_valid), XLEN'(e_rsp && cur.is_data));
    check_eq("d_rsp_data", d_rsp_data, (e_rsp && cur.is_data) ? e_data : '0);
    check_eq("bus_error", XLEN'(bus_error), XLEN'(err_seen));
    @(posedge clk);
    if (!rst) begin
      pending = 0; last_data = 1; err_seen = 0;
    end else if (!pending) begin
      if (e_ifr) begin
        cur = '{is_data: 0, we: 0, addr: ia, wdata: '0, mem_took: 0, waited: 0};
        pending = 1; last_data = 0; grants_if++;
      end else if (e_dr) begin
        cur = '{is_data: 1, we: dwe, addr: da, wdata: dw, mem_took: 0, waited: 0};
        pending = 1; last_data = 1; grants_d++;
      end
    end else if (!cur.mem_took) begin
      if (mrr) cur.mem_took = 1;
    end else if (e_rsp) begin
      if (e_to) err_seen = 1;
      pending = 0;
    end else begin
      cur.waited++;
    end
  endtask

  task automatic idle_step(input bit mrr, input bit mrv, input logic [XLEN-1:0] mrd);
    step(1, 0, '0, 0, 0, '0, '0, mrr, mrv, mrd);
  endtask

  initial begin
    n_rst = 0; if_req_valid = 0; if_addr = '0; d_req_valid = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    repeat (2) @(posedge clk);
    step(0, 0, '0, 0, 0, '0, '0, 0, 0, '0);

    // Fetch at minimum latency.
    step(1, 1, 32'h100, 0, 0, '0, '0, 0, 0, '0);
    idle_step(1, 0, '0);
    idle_step(0, 1, 32'h0050_0093);

    // Store with memory stalling the request for three cycles.
    step(1, 0, '0, 1, 1, 32'h200, 32'hDEAD_BEEF, 0, 0, '0);
    repeat (3) step(1, 1, 32'h300, 0, 0, '0, '0, 0, 0, '0);
    idle_step(1, 0, '0);
    step(1, 1, 32'h300, 1, 0, 32'h400, '0, 0, 1, 32'h1234_5678);

    // Spurious response while idle, then both sides requesting every cycle from reset.
    idle_step(0, 1, 32'hAAAA_5555);
    step(0, 0, '0, 0, 0, '0, '0, 0, 0, '0);
    grants_if = 0; grants_d = 0;
    repeat (12) step(1, 1, 32'h500, 1, 0, 32'h600, '0, 1, 1, 32'hCAFE_0001);
    check_eq("alternation_if", XLEN'(grants_if), XLEN'(2));
    check_eq("alternation_d", XLEN'(grants_d), XLEN'(2));

    // Reset while waiting for the response.
    step(1, 0, '0, 1, 0, 32'h700, '0, 0, 0, '0);
    idle_step(1, 0, '0);
    idle_step(0, 0, '0);
    step(0, 0, '0, 0, 0, '0, '0, 0, 1, 32'h7777_7777);
    step(1, 1, 32'h800, 1, 0, 32'h900, '0, 0, 0, '0);
    check_eq("tie_after_reset", XLEN'(grants_if), XLEN'(3));

    // Load that memory never answers (times out when the watchdog is built in).
    idle_step(1, 0, '0);
    repeat (8) idle_step(0, 0, '0);
    idle_step(0, 1, 32'h1);
    step(1, 0, '0, 1, 0, 32'hA00, '0, 0, 0, '0);
    idle_step(1, 0, '0);
    repeat (TO + 2) idle_step(0, 0, '0);
    idle_step(0, 1, 32'h2);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(63) != 0), $urandom_range(1), $urandom,
           $urandom_range(1), $urandom_range(1), $urandom, $urandom,
           $urandom_range(1), ($urandom_range(3) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
